bcd_updown_display: RTL and testbench
=====================================

# bcd_updown_display

Parametrised N-digit BCD up/down counter with load, enable and wrap pulse, driving a time-multiplexed active-low 8-anode seven-segment display. It succeeds the fixed 3-bit single-digit counter and display path. Its internal tick divider replaces the separate slow-clock generator, so the whole block runs on `sysCLK` with no derived clocks. It sits between board switches and buttons and the on-board display.

## Interface
- `DIGITS`, 4, number of BCD digits, legal 1..8
- `TICK_DIV`, 50_000_000, `sysCLK` cycles per count step, ≥1 (1 = step every cycle)
- `SCAN_DIV`, 100_000, `sysCLK` cycles each digit is lit, ≥1
- `BLANK_LZ`, 1, 1 = blank leading zeros (digit 0 always shown)

- `sysCLK` in 1: system clock, all logic on rising edge
- `reset` in 1: one clock; reset is synchronous and active-high
- `en` in 1: count enable, sampled on tick
- `up` in 1: 1 = count up, 0 = count down, sampled on tick
- `load` in 1: synchronous load request
- `load_val` in 4*DIGITS: BCD load value, digit i at [4i+3:4i]
- `count` out 4*DIGITS: current BCD value
- `tc` out 1: one-cycle pulse on wrap
- `Cx` out 8: active-low segments, bit 7 = dp, bits 6..0 = g..a
- `AN` out 8: active-low anodes, AN[i] = digit i (digit 0 least significant)

## Operation
- Tick divider: counter 0..TICK_DIV-1, free-running. `tick` is high for one cycle when the counter equals TICK_DIV-1, and the counter returns to 0. Not cleared by `load` or `en`.
- Counter update priority: `reset` > `load` > (`tick` & `en`) > hold.
- `load`: each digit of `load_val` is registered. Digits >9 load as 0. `tc` stays 0. A tick in the same cycle is dropped.
- Up step: BCD increment with ripple carry. All-9s wraps to 0 and `tc`=1.
- Down step: BCD decrement with ripple borrow. 0 wraps to all-9s and `tc`=1.
- `tc` is asserted only on wrap, never on load.
- Scan: divider 0..SCAN_DIV-1. On terminal count, the digit index advances 0→1→…→DIGITS-1→0.
- Selected digit i: AN[i]=0, all other AN bits=1. AN bits ≥DIGITS are always 1.
- Segment codes, dp always off (bit7=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
  - blank=FF
- Leading-zero blanking (BLANK_LZ=1): digit i>0 is blank if it and every higher digit are 0.

## Timing
- Reset values: `count`=0, `tc`=0, `Cx`=8'hFF, `AN`=8'hFF, both dividers=0, scan index=0.
- `count` and `tc` are registered. They update in the cycle after the tick or load edge, and `tc` aligns with the wrapped `count` value.
- `Cx` and `AN` are registered, with 1-cycle latency from scan index or `count` change.
- First cycle after reset release: `Cx`/`AN` show digit 0. The first tick occurs TICK_DIV cycles after release.
- `up` toggling between ticks has no effect until the next tick.
- Reset mid-operation: every register returns to its reset value on the next edge, and no `tc` is issued.
- Dividers use $clog2 width (minimum 1 bit). Compare with ==, never overflow.

## Structure
- Package `bcd_disp_pkg`:
  - SEG_0..SEG_9 and SEG_BLANK constants
  - `bcd_to_seg` function
  - `bcd_t` (4-bit) typedef
- Sub-module `bcd_digit`: one digit with `inc`/`dec`/`load` inputs and carry/borrow out. Generated DIGITS times and chained.
- Tick divider, scan divider and display mux live in the top module.

## Test plan
Bench parameters: DIGITS=2, TICK_DIV=4, SCAN_DIV=2.
- Reset held 3 cycles, then released with en=1, up=1 → `Cx`/`AN`=FF during reset. `count` steps 00→01→02 every 4 cycles, and `tc`=0.
- load 0x99, up=1 → next tick `count`=0x00 with `tc`=1 for exactly one cycle. Following tick → 0x01 with `tc`=0.
- load 0x00, up=0 → next tick `count`=0x99 and `tc` pulses once.
- load=1 with load_val=0x3A in the tick cycle → `count`=0x30, `tc`=0, and no step that tick.
- `count`=0x07, BLANK_LZ=1 → AN alternates FE/FD every 2 cycles. `Cx`=F8 when AN=FE and `Cx`=FF when AN=FD. AN[7:2] always 1.
- en=0 for 10 ticks → `count` holds. Assert reset mid-count at 0x45 → `count`=0 and `tc`=0 on the next edge.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared types, seven-segment codes and the BCD-to-segment decoder for the
// up/down BCD counter display.
package bcd_disp_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Active-low segments, bit 7 = dp (kept off), bits 6..0 = g..a.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] bcd_to_seg(input bcd_t d);
        case (d)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_updown_display_digit.sv
// One BCD digit with load, increment and decrement; carry/borrow are
// combinational so a chain of digits ripples within a single step.
module bcd_digit
    import bcd_disp_pkg::*;
(
    input  logic sysCLK,
    input  logic reset,
    input  logic load,
    input  bcd_t load_val,
    input  logic inc,
    input  logic dec,
    output bcd_t q,
    output logic carry,
    output logic borrow
);

    bcd_t q_r;

    assign q      = q_r;
    assign carry  = inc & (q_r == BCD_MAX);
    assign borrow = dec & (q_r == 4'd0);

    // Digit register: reset > load > increment > decrement > hold.
    always_ff @(posedge sysCLK) begin
        if (reset) begin
            q_r <= 4'd0;
        end else if (load) begin
            q_r <= (load_val > BCD_MAX) ? 4'd0 : load_val;
        end else if (inc) begin
            q_r <= carry ? 4'd0 : q_r + 4'd1;
        end else if (dec) begin
            q_r <= borrow ? BCD_MAX : q_r - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_updown_display.sv
// N-digit BCD up/down counter with a time-multiplexed active-low 8-anode
// seven-segment display, all on sysCLK with internal tick and scan dividers.
module bcd_updown_display
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 100_000,
    parameter int BLANK_LZ = 1
) (
    input  logic                  sysCLK,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic [7:0]            Cx,
    output logic [7:0]            AN
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [TW-1:0] tick_cnt_r;
    logic [SW-1:0] scan_cnt_r;
    logic [IW-1:0] idx_r;
    logic          tc_r;
    logic [7:0]    cx_r;
    logic [7:0]    an_r;
    logic          tick_s;
    logic          step_up_s;
    logic          step_dn_s;
    logic          wrap_s;
    bcd_t          sel_s;
    logic          sel_blank_s;
    logic          zero_run_s;
    logic [7:0]    seg_s;
    logic [7:0]    an_s;

    assign tick_s    = (tick_cnt_r == TICK_LAST);
    // A load in the tick cycle swallows that tick's step.
    assign step_up_s = tick_s & en & up & ~load;
    assign step_dn_s = tick_s & en & ~up & ~load;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic inc_s, dec_s, carry_s, borrow_s;
        bcd_t q_s;
        if (i == 0) begin : g_lsd
            assign inc_s = step_up_s;
            assign dec_s = step_dn_s;
        end else begin : g_chain
            assign inc_s = g_dig[i-1].carry_s;
            assign dec_s = g_dig[i-1].borrow_s;
        end
        bcd_digit u_digit (
            .sysCLK   (sysCLK),
            .reset    (reset),
            .load     (load),
            .load_val (load_val[4*i +: 4]),
            .inc      (inc_s),
            .dec      (dec_s),
            .q        (q_s),
            .carry    (carry_s),
            .borrow   (borrow_s)
        );
        assign count[4*i +: 4] = q_s;
    end

    assign wrap_s = g_dig[DIGITS-1].carry_s | g_dig[DIGITS-1].borrow_s;

    // Free-running tick divider and wrap pulse, aligned with the wrapped count.
    always_ff @(posedge sysCLK) begin
        if (reset) begin
            tick_cnt_r <= '0;
            tc_r       <= 1'b0;
        end else begin
            tick_cnt_r <= tick_s ? '0 : tick_cnt_r + TW'(1);
            tc_r       <= wrap_s;
        end
    end

    // Scan divider and digit index.
    always_ff @(posedge sysCLK) begin
        if (reset) begin
            scan_cnt_r <= '0;
            idx_r      <= '0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= '0;
            idx_r      <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
        end else begin
            scan_cnt_r <= scan_cnt_r + SW'(1);
        end
    end

    // Pick the scanned digit; a digit is a leading zero if it and all above are 0.
    always_comb begin
        sel_s       = 4'd0;
        sel_blank_s = 1'b0;
        zero_run_s  = 1'b1;
        an_s        = 8'hFF;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run_s  = zero_run_s & (count[4*i +: 4] == 4'd0);
            sel_s       = (IW'(i) == idx_r) ? count[4*i +: 4] : sel_s;
            sel_blank_s = (IW'(i) == idx_r) ? (zero_run_s & (i != 0)) : sel_blank_s;
        end
        seg_s = ((BLANK_LZ != 0) && sel_blank_s) ? SEG_BLANK : bcd_to_seg(sel_s);
        an_s[3'(idx_r)] = 1'b0;
    end

    // Registered display outputs.
    always_ff @(posedge sysCLK) begin
        if (reset) begin
            cx_r <= 8'hFF;
            an_r <= 8'hFF;
        end else begin
            cx_r <= seg_s;
            an_r <= an_s;
        end
    end

    assign tc = tc_r;
    assign Cx = cx_r;
    assign AN = an_r;

endmodule

// File: tb/tb_bcd_updown_display.sv
// Directed bench for bcd_updown_display with DIGITS=2, TICK_DIV=4, SCAN_DIV=2.
module tb_bcd_updown_display;

    logic       sysCLK = 1'b0;
    logic       reset, en, up, load;
    logic [7:0] load_val, count, Cx, AN;
    logic       tc;
    int         checks = 0;
    int         failures = 0;
    int         k = 0;

    always #5 sysCLK = ~sysCLK;

    bcd_updown_display #(
        .DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1)
    ) dut (
        .sysCLK(sysCLK), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .Cx(Cx), .AN(AN)
    );

    typedef struct {
        logic       ld;
        logic [7:0] lv;
        logic       en;
        logic       up;
        logic [7:0] ec;
        logic       etc;
    } vec_t;

    vec_t tbl[28];

    task automatic step();
        @(posedge sysCLK);
        #1;
        k++;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic [7:0] lv, input logic e,
                                input logic u, input logic [7:0] ec, input logic etc);
        vec_t v;
        v.ld = ld; v.lv = lv; v.en = e; v.up = u; v.ec = ec; v.etc = etc;
        return v;
    endfunction

    // Scan index after edge m is (m/2)%2, so AN at edge k reflects edge k-1.
    function automatic logic [7:0] exp_an(input int kk);
        return ((((kk - 1) / 2) % 2) == 1) ? 8'hFD : 8'hFE;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog k=%0d actual=running required=finished", k);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ean;
        reset = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_count", count, 8'h00);
            chk("rst_tc", {7'd0, tc}, 8'h00);
            chk("rst_cx", Cx, 8'hFF);
            chk("rst_an", AN, 8'hFF);
        end
        k = 0;
        reset = 1'b0;

        // Edge k is the k-th edge after reset release; ticks land on k%4==0.
        tbl[0]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
        tbl[1]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
        tbl[2]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
        tbl[3]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0);
        tbl[4]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0);
        tbl[5]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0);
        tbl[6]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0);
        tbl[7]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0);
        tbl[8]  = mk(1'b1, 8'h99, 1'b1, 1'b1, 8'h99, 1'b0);
        tbl[9]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 1'b0);
        tbl[10] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 1'b0);
        tbl[11] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
        tbl[12] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
        tbl[13] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
        tbl[14] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
        tbl[15] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0);
        tbl[16] = mk(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[17] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[18] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[19] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b1);
        tbl[20] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b0);
        tbl[21] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b0);
        tbl[22] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b0);
        tbl[23] = mk(1'b1, 8'h3A, 1'b1, 1'b1, 8'h30, 1'b0);
        tbl[24] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 1'b0);
        tbl[25] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 1'b0);
        tbl[26] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 1'b0);
        tbl[27] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h31, 1'b0);

        for (int i = 0; i < 28; i++) begin
            load = tbl[i].ld; load_val = tbl[i].lv; en = tbl[i].en; up = tbl[i].up;
            step();
            chk("tbl_count", count, tbl[i].ec);
            chk("tbl_tc", {7'd0, tc}, {7'd0, tbl[i].etc});
            chk("tbl_an", AN, exp_an(k));
            if (i == 0) chk("first_cx_digit0", Cx, 8'hC0);
        end

        // Count 07 held with en=0 for ten ticks; digit 1 is a blanked leading zero.
        load = 1'b1; load_val = 8'h07; en = 1'b0; up = 1'b1;
        step();
        chk("load07", count, 8'h07);
        load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            ean = exp_an(k);
            chk("hold_count", count, 8'h07);
            chk("hold_tc", {7'd0, tc}, 8'h00);
            chk("scan_an", AN, ean);
            chk("scan_cx", Cx, (ean == 8'hFE) ? 8'hF8 : 8'hFF);
        end

        // Reset mid-count at 0x45.
        load = 1'b1; load_val = 8'h44; en = 1'b1; up = 1'b1;
        step();
        chk("load44", count, 8'h44);
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (count == 8'h45) break;
            step();
        end
        chk("reach_45", count, 8'h45);
        reset = 1'b1;
        step();
        chk("midrst_count", count, 8'h00);
        chk("midrst_tc", {7'd0, tc}, 8'h00);
        chk("midrst_cx", Cx, 8'hFF);
        chk("midrst_an", AN, 8'hFF);
        reset = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            step();
            chk("post_rst_count", count, (j == 4) ? 8'h01 : 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
